// File: rtl/mini_core_mem_arb.sv
// mini_core_mem_arb: shares one single-port memory between the fetch (F) and
// data/LSU (D) ports of mini_core. Request/grant is combinational; read data
// comes back one cycle after an accepted read and is steered to its owner.
// Optional feature macro: MINI_CORE_ARB_RR_EN (round-robin on conflict instead
// of fixed D-priority with a fetch starvation bound).
module mini_core_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,      // async, active-low
    // fetch port
    input  logic                i_f_req,
    input  logic [ADDR_W-1:0]   i_f_addr,
    output logic                o_f_gnt,
    output logic                o_f_rvalid,
    output logic [DATA_W-1:0]   o_f_rdata,
    // data / LSU port
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [DATA_W/8-1:0] i_d_be,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,
    // shared memory port
    input  logic                i_m_ready,
    output logic                o_m_req,
    output logic                o_m_we,
    output logic [DATA_W/8-1:0] o_m_be,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    input  logic [DATA_W-1:0]   i_m_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RSP_F = 2'd1,
        ST_RSP_D = 2'd2
    } rsp_st_t;

    rsp_st_t     r_rsp_st;
    logic        w_f_prio;     // F wins if both request this cycle
    logic        w_f_win;
    logic        w_f_gnt;
    logic        w_d_gnt;

`ifdef MINI_CORE_ARB_RR_EN
    // r_rr_last remembers which side lost the previous conflict; that side
    // is owed the next one. Reset value SIDE_D hands the first conflict to D.
    localparam logic SIDE_F = 1'b0;
    localparam logic SIDE_D = 1'b1;
    logic r_rr_last;

    assign w_f_prio = (r_rr_last == SIDE_F);

    // Record the loser of every conflict that actually gets a grant
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr_last <= SIDE_D;
        end else if (i_f_req && i_d_req && (w_f_gnt || w_d_gnt)) begin
            r_rr_last <= w_f_gnt ? SIDE_D : SIDE_F;
        end
    end
`else
    logic [3:0] r_starve_cnt;

    assign w_f_prio = (r_starve_cnt == 4'(STARVE_MAX));

    // Count consecutive D wins while F waits; frozen when memory is not ready
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_starve_cnt <= '0;
        end else if (!i_f_req || w_f_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_d_gnt && (r_starve_cnt != 4'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    assign w_f_win = i_f_req & (~i_d_req | w_f_prio);
    // No grant while held in reset or while memory stalls
    assign w_f_gnt = i_rst & i_m_ready & w_f_win;
    assign w_d_gnt = i_rst & i_m_ready & i_d_req & ~w_f_win;

    assign o_f_gnt = w_f_gnt;
    assign o_d_gnt = w_d_gnt;
    assign o_m_req = i_f_req | i_d_req;

    // Memory port mux: F fields only when F is granted, D fields otherwise
    always_comb begin
        o_m_we    = i_d_we;
        o_m_be    = i_d_we ? i_d_be : {BE_W{1'b1}};
        o_m_addr  = i_d_addr;
        o_m_wdata = i_d_wdata;
        if (w_f_gnt) begin
            o_m_we    = 1'b0;
            o_m_be    = {BE_W{1'b1}};
            o_m_addr  = i_f_addr;
            o_m_wdata = '0;
        end
    end

    // Response owner for next cycle's read data; stores take no slot
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rsp_st <= ST_IDLE;
        end else if (w_f_gnt) begin
            r_rsp_st <= ST_RSP_F;
        end else if (w_d_gnt && !i_d_we) begin
            r_rsp_st <= ST_RSP_D;
        end else begin
            r_rsp_st <= ST_IDLE;
        end
    end

    assign o_f_rvalid = (r_rsp_st == ST_RSP_F);
    assign o_d_rvalid = (r_rsp_st == ST_RSP_D);
    assign o_f_rdata  = o_f_rvalid ? i_m_rdata : '0;
    assign o_d_rdata  = o_d_rvalid ? i_m_rdata : '0;

endmodule

// File: tb/tb_mini_core_mem_arb.sv
// Bench for mini_core_mem_arb: directed vectors, a queue-free behavioural
// model checked every cycle, plus literal expectations from hand analysis.
module tb_mini_core_mem_arb;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] f_addr = '0, d_addr = '0;
    logic [BW-1:0] d_be = '0;
    logic [DW-1:0] d_wdata = '0, m_rdata = '0;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid, m_req, m_we;
    logic [DW-1:0] f_rdata, d_rdata, m_wdata;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;

    int total = 0;
    int bad   = 0;

    mini_core_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
        .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
        .o_d_rdata(d_rdata),
        .i_m_ready(m_ready), .o_m_req(m_req), .o_m_we(m_we), .o_m_be(m_be),
        .o_m_addr(m_addr), .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_dwins: D wins in a row while F waited; m_d_due: D owed next conflict;
    // m_rsp: who receives read data this cycle (0 none, 1 F, 2 D)
    int m_dwins;
    bit m_d_due;
    int m_rsp;
    int mw, cw;

    // Winner this cycle from the rules: 0 none, 1 F, 2 D
    function automatic int winner();
        if (!rst || !m_ready || (!f_req && !d_req)) return 0;
        if (f_req && !d_req) return 1;
        if (d_req && !f_req) return 2;
`ifdef MINI_CORE_ARB_RR_EN
        return m_d_due ? 2 : 1;
`else
        return (m_dwins >= SMAX) ? 1 : 2;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_dwins <= 0;
            m_d_due <= 1'b1;
            m_rsp   <= 0;
        end else begin
            mw = winner();
            m_rsp <= (mw == 1) ? 1 : ((mw == 2 && !d_we) ? 2 : 0);
            if (f_req && d_req && mw != 0) m_d_due <= (mw == 1);
            if (!f_req || mw == 1) m_dwins <= 0;
            else if (mw == 2 && m_dwins < SMAX) m_dwins <= m_dwins + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        cw = winner();
        chk("f_gnt", 64'(f_gnt), 64'(cw == 1));
        chk("d_gnt", 64'(d_gnt), 64'(cw == 2));
        chk("m_req", 64'(m_req), 64'(f_req | d_req));
        if (cw == 1) begin
            chk("m_we_f", 64'(m_we), 64'd0);
            chk("m_be_f", 64'(m_be), 64'hF);
            chk("m_addr_f", 64'(m_addr), 64'(f_addr));
        end else begin
            chk("m_we_d", 64'(m_we), 64'(d_we));
            chk("m_be_d", 64'(m_be), d_we ? 64'(d_be) : 64'hF);
            chk("m_addr_d", 64'(m_addr), 64'(d_addr));
            chk("m_wdata_d", 64'(m_wdata), 64'(d_wdata));
        end
        chk("f_rvalid", 64'(f_rvalid), 64'(m_rsp == 1));
        chk("d_rvalid", 64'(d_rvalid), 64'(m_rsp == 2));
        chk("f_rdata", 64'(f_rdata), (m_rsp == 1) ? 64'(m_rdata) : 64'd0);
        chk("d_rdata", 64'(d_rdata), (m_rsp == 2) ? 64'(m_rdata) : 64'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pat[10];
    int exp3[10];
    int exp4a[2];
    int exp4b[3];

    initial begin
`ifdef MINI_CORE_ARB_RR_EN
        exp3  = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
        exp4a = '{2, 1};
        exp4b = '{2, 1, 2};
`else
        exp3  = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        exp4a = '{2, 2};
        exp4b = '{2, 2, 1};
`endif
        // reset: requests present but no grants, no responses
        f_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_f_gnt", 64'(f_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
        chk("rst_rdata", 64'(f_rdata | d_rdata), 64'd0);
        tick();
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0;

        // 1. fetch only
        tick();
        f_req = 1'b1; f_addr = 32'h100; m_rdata = 32'h13;
        @(negedge clk);
        chk("t1_gnt", 64'(f_gnt), 64'd1);
        chk("t1_addr", 64'(m_addr), 64'h100);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", 64'(f_rvalid), 64'd1);
        chk("t1_rdata", 64'(f_rdata), 64'h13);

        // 2. data store
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_be = 4'h3; d_wdata = 32'hBEEF;
        @(negedge clk);
        chk("t2_gnt", 64'(d_gnt), 64'd1);
        chk("t2_we", 64'(m_we), 64'd1);
        chk("t2_be", 64'(m_be), 64'h3);
        chk("t2_wdata", 64'(m_wdata), 64'hBEEF);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("t2_no_rvalid", 64'(d_rvalid), 64'd0);

        // 3. sustained conflict with loads
        tick();
        f_req = 1'b1; f_addr = 32'h400; d_req = 1'b1; d_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            m_rdata = 32'h1000 + 32'(i);
            @(negedge clk);
            pat[i] = f_gnt ? 1 : (d_gnt ? 2 : 0);
            chk("t3_pattern", 64'(pat[i]), 64'(exp3[i]));
            tick();
        end

        // 4. stall with both held: no grants, arbitration state frozen
        for (int i = 0; i < 2; i++) begin
            m_rdata = 32'h2000 + 32'(i);
            @(negedge clk);
            chk("t4_pre", 64'(f_gnt ? 1 : (d_gnt ? 2 : 0)), 64'(exp4a[i]));
            tick();
        end
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_gnt", 64'({f_gnt, d_gnt}), 64'd0);
            if (i > 0) chk("t4_stall_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_rdata = 32'h3000 + 32'(i);
            @(negedge clk);
            chk("t4_post", 64'(f_gnt ? 1 : (d_gnt ? 2 : 0)), 64'(exp4b[i]));
            tick();
        end

        // 5. back-to-back: D load then F read
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; m_rdata = 32'hAAAA_0001;
        @(negedge clk);
        chk("t5_d_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0; f_req = 1'b1; f_addr = 32'h104; m_rdata = 32'hBBBB_0002;
        @(negedge clk);
        chk("t5_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("t5_d_rdata", 64'(d_rdata), 64'hBBBB_0002);
        chk("t5_f_gnt", 64'(f_gnt), 64'd1);
        chk("t5_f_quiet", 64'(f_rvalid), 64'd0);
        tick();
        f_req = 1'b0; m_rdata = 32'hCCCC_0003;
        @(negedge clk);
        chk("t5_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("t5_f_rdata", 64'(f_rdata), 64'hCCCC_0003);
        chk("t5_d_quiet", 64'(d_rvalid), 64'd0);

        // 6. reset right after a D load grant drops the response
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        @(negedge clk);
        chk("t6_d_gnt", 64'(d_gnt), 64'd1);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_no_rvalid", 64'(d_rvalid), 64'd0);
        chk("t6_gnt_forced", 64'({f_gnt, d_gnt}), 64'd0);
        tick();
        rst = 1'b1; d_req = 1'b0; f_req = 1'b1; f_addr = 32'h500; m_rdata = 32'h55;
        @(negedge clk);
        chk("t6_f_gnt", 64'(f_gnt), 64'd1);
        chk("t6_still_quiet", 64'(d_rvalid), 64'd0);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        chk("t6_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("t6_f_rdata", 64'(f_rdata), 64'h55);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
